// File: rtl/display_scan_ctrl.sv
// Multiplexed symbol display scanner with double-buffered frames.
// Blank gap before each digit, frame-boundary commit of new frames.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [3*NUM_DIGITS-1:0] load_data,
  output logic                    load_ack,
  output logic [2:0]              sym_code,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    frame_start
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int FW   = 3 * NUM_DIGITS;

  localparam logic [CW-1:0] PLAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   idx, idx_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [FW-1:0]   active, active_d;
  logic [FW-1:0]   shadow, shadow_d;
  logic            pending, pending_d;
  logic            commit;
  logic            ack_d, fs_d;
  logic [2:0]      sym_d;
  logic [NUM_DIGITS-1:0] dig_d;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        commit = pending | load;
        if (enable) begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt == BLAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHOW: begin
        commit = (idx == ILAST) && (cnt == PLAST)
               && (pending | load);
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt == PLAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx == ILAST) ? '0 : idx + 1'b1;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // a load on the commit cycle bypasses the shadow buffer
    shadow_d  = load ? load_data : shadow;
    active_d  = commit ? shadow_d : active;
    pending_d = commit ? 1'b0 : (load | pending);
    ack_d     = commit;

    dig_d = '1;
    sym_d = 3'b000;
    fs_d  = 1'b0;
    if (state_d != IDLE) begin
      sym_d = active_d[3*idx_d +: 3];
      if (state_d == SHOW)
        dig_d = ~(NUM_DIGITS'(1) << idx_d);
      fs_d = (state_d == BLANK) && (idx_d == '0)
           && (cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cnt         <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      load_ack    <= 1'b0;
      sym_code    <= 3'b000;
      digit_en_n  <= '1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      cnt         <= cnt_d;
      active      <= active_d;
      shadow      <= shadow_d;
      pending     <= pending_d;
      load_ack    <= ack_d;
      sym_code    <= sym_d;
      digit_en_n  <= dig_d;
      frame_start <= fs_d;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed plan plus random traffic
// against a phase-arithmetic frame model.
module tb_display_scan_ctrl;
  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 2;
  localparam int S = B + P;
  localparam int F = N * S;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          load = 1'b0;
  logic [3*N-1:0] load_data = '0;
  logic          load_ack;
  logic [2:0]    sym_code;
  logic [N-1:0]  digit_en_n;
  logic          frame_start;

  display_scan_ctrl #(
    .NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .load(load), .load_data(load_data),
    .load_ack(load_ack), .sym_code(sym_code),
    .digit_en_n(digit_en_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, got, exp, $time);
  endtask

  // model: phase = cycles since scanning (re)started, -1 when dark
  int         phase = -1;
  logic [2:0] m_act [N];
  logic [2:0] m_sh  [N];
  bit         m_pend;
  bit         m_commit;
  bit         run = 0;
  logic [N-1:0] e_dig;
  logic [2:0]   e_sym;
  bit           e_ack, e_fs;

  always @(posedge clk) begin
    if (!rst_n) begin
      phase  = -1;
      m_pend = 0;
      e_ack  = 0;
      for (int i = 0; i < N; i++) begin
        m_act[i] = 3'b000;
        m_sh[i]  = 3'b000;
      end
      run = 1;
    end else begin
      m_commit = (phase < 0 || phase == F - 1) && (m_pend || load);
      if (load)
        for (int i = 0; i < N; i++) m_sh[i] = load_data[3*i +: 3];
      if (m_commit) begin
        for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
        m_pend = 0;
      end else if (load) begin
        m_pend = 1;
      end
      e_ack = m_commit;
      if (!enable) phase = -1;
      else if (phase < 0) phase = 0;
      else phase = (phase + 1) % F;
    end
    e_dig = '1;
    e_sym = 3'b000;
    e_fs  = 0;
    if (phase >= 0) begin
      e_sym = m_act[(phase / S) % N];
      if (phase % S >= B) e_dig[(phase / S) % N] = 1'b0;
      e_fs = (phase == 0);
    end
  end

  logic [2:0] prev_sym = 3'b000;
  always @(negedge clk) begin
    if (run) begin
      chk("digit_en_n", digit_en_n, e_dig);
      chk("sym_code", sym_code, e_sym);
      chk("load_ack", load_ack, e_ack);
      chk("frame_start", frame_start, e_fs);
      chk("one_digit_max", ($countones(~digit_en_n) <= 1), 1);
      if (digit_en_n != '1)
        chk("sym_stable_when_lit", sym_code, prev_sym);
      prev_sym = sym_code;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  logic [11:0] va, vb, vc, vd;
  int acks;

  initial begin
    va = 12'b001_001_010_100;
    vb = 12'b010_100_001_010;
    vc = 12'b100_100_001_001;
    vd = 12'b111_010_100_001;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) begin
      step();
      chk("idle_dark", digit_en_n, 4'b1111);
      chk("idle_sym", sym_code, 3'b000);
      chk("idle_no_fs", frame_start, 0);
      chk("idle_no_ack", load_ack, 0);
    end

    load = 1'b1;
    load_data = 12'b100_010_001_111;
    step();
    chk("idle_load_ack", load_ack, 1);
    load = 1'b0;
    step();
    chk("ack_one_cycle", load_ack, 0);

    enable = 1'b1;
    step();
    chk("first_fs", frame_start, 1);
    chk("blank0_dark", digit_en_n, 4'b1111);
    chk("blank0_sym", sym_code, 3'b111);
    step();
    chk("blank1_dark", digit_en_n, 4'b1111);
    step();
    chk("d0_lit", digit_en_n, 4'b1110);
    chk("d0_sym", sym_code, 3'b111);
    repeat (3) step();
    chk("d0_last", digit_en_n, 4'b1110);
    step();
    chk("d1_blank", digit_en_n, 4'b1111);
    chk("d1_sym", sym_code, 3'b001);
    repeat (2) step();
    chk("d1_lit", digit_en_n, 4'b1101);
    repeat (16) step();
    chk("fs_period", frame_start, 1);

    repeat (5) step();
    load = 1'b1; load_data = va;
    step();
    load = 1'b0;
    repeat (2) step();
    load = 1'b1; load_data = vb;
    step();
    load = 1'b0;
    acks = 0;
    repeat (24) begin
      step();
      if (load_ack === 1'b1) acks++;
    end
    chk("single_ack", acks, 1);
    chk("b_shown", sym_code, vb[5:3]);

    repeat (14) step();
    load = 1'b1; load_data = vc;
    step();
    load = 1'b0;
    chk("bypass_ack", load_ack, 1);
    chk("bypass_fs", frame_start, 1);
    chk("bypass_sym", sym_code, vc[2:0]);

    repeat (15) step();
    chk("d2_lit", digit_en_n, 4'b1011);
    enable = 1'b0;
    step();
    chk("disable_dark", digit_en_n, 4'b1111);
    chk("disable_sym", sym_code, 3'b000);
    enable = 1'b1;
    step();
    chk("reenable_fs", frame_start, 1);

    repeat (4) step();
    load = 1'b1; load_data = vd;
    step();
    load = 1'b0;
    rst_n = 1'b0;
    step();
    chk("rst_dark", digit_en_n, 4'b1111);
    chk("rst_sym", sym_code, 3'b000);
    chk("rst_ack", load_ack, 0);
    rst_n = 1'b1;
    step();
    chk("rst_restart_fs", frame_start, 1);
    chk("rst_active_zero", sym_code, 3'b000);
    chk("rst_no_ack", load_ack, 0);

    for (int c = 0; c < 3000; c++) begin
      load      = ($urandom_range(7) == 0);
      load_data = 12'($urandom);
      if ($urandom_range(79) == 0) enable = ~enable;
      rst_n     = ($urandom_range(599) != 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexes one shared 3-bit symbol decoder (one-hot code: 100 '=', 010 '>', 001 '<', anything else '-') across NUM_DIGITS common-anode digit positions of the comparator result display. Holds a double-buffered symbol frame and cycles through the digits with a programmable dwell time. Inserts a blanking gap between digits to suppress ghosting. Upstream comparator logic loads new frames with a load/ack handshake; updates apply only at frame boundaries, so a frame is never shown half-old, half-new.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (>=2)
PRESCALE, 50000, clk cycles each digit is lit (>=1)
BLANK_CYCLES, 16, clk cycles all digits are dark before each digit (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
enable  input  1  1 = scanning, 0 = display dark
load  input  1  single-cycle request to capture load_data
load_data  input  3*NUM_DIGITS  symbol codes; digit i = bits [3i+2:3i]
load_ack  output  1  one-cycle pulse when a captured frame becomes active
sym_code  output  3  code to the shared decoder for the current digit
digit_en_n  output  NUM_DIGITS  active-low digit enables, at most one low
frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE, digit index 0, counters 0, active and shadow buffers all 3'b000, pending=0. Outputs: digit_en_n all 1, sym_code 3'b000, load_ack 0, frame_start 0. Reset mid-frame discards any pending load without an ack.
- All outputs are registered.
- States: IDLE, BLANK, SHOW.
- IDLE: digit_en_n all 1, sym_code 3'b000. If enable=1, go to BLANK with index 0 next cycle.
- BLANK: lasts BLANK_CYCLES cycles. digit_en_n all 1. sym_code = active[index] from the first BLANK cycle, so the decoder settles before the digit lights. frame_start=1 on the first BLANK cycle of index 0. After the last cycle, go to SHOW.
- SHOW: lasts PRESCALE cycles. digit_en_n[index]=0, all other bits 1. sym_code unchanged. After the last cycle, increment index, wrapping NUM_DIGITS-1 -> 0, and go to BLANK.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- Load: load=1 copies load_data into shadow and sets pending on the same edge. A second load while pending overwrites shadow; only one ack is issued, for the latest data.
- Commit point: the last SHOW cycle of index NUM_DIGITS-1. If pending=1 (or load=1 on that same cycle), copy shadow into active, clear pending and pulse load_ack on the next cycle. If load=1 on the commit cycle itself, load_data bypasses shadow and is committed directly. The new frame first appears in the following BLANK of index 0.
- In IDLE, a pending or incoming load commits on the next edge with load_ack, so the display does not wait for a frame.
- enable falls in BLANK or SHOW: next cycle goes to IDLE, index is reset to 0, all digits dark. An uncommitted pending load then commits per the IDLE rule. Re-enabling always restarts at index 0 with frame_start.
- Invariant: digit_en_n never has more than one bit low. No digit is ever lit in the same cycle sym_code changes.

Test Plan:
Use NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2 throughout.
- Reset, enable=0 for 10 cycles -> digit_en_n=4'b1111, sym_code=000, no pulses.
- Load 12'b100_010_001_111 while disabled -> load_ack 1 cycle later. Then enable -> frame_start, then 2 dark cycles, then digit0 low for 4 cycles with sym_code=111, then digit1 with 001, digit2 with 010, digit3 with 100. Frame = 24 cycles and frame_start repeats every 24 cycles.
- While enabled mid-frame, load A then load B 3 cycles later -> exactly one load_ack, at the frame boundary. Next frame displays B, and the current frame finishes unchanged.
- Assert load exactly on the commit cycle with data C -> load_ack on the next cycle, and C is shown from the next frame's digit0.
- Drop enable during SHOW of digit2 -> next cycle all digits dark, IDLE. Re-enable -> restarts at digit0 with frame_start.
- Assert rst_n=0 during SHOW with a load pending -> all outputs return to reset values, no load_ack, active buffer is 000. Throughout all tests, assert digit_en_n is never low for more than one bit at a time.
